hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 Rs1D, Rs2D  in  5  source register indices of the instruction in Decode.
REQ-004 Rs1E, Rs2E  in  5  source register indices of the instruction in Execute.
REQ-005 RdE, RdM, RdW  in  5  destination indices in Execute, Memory and Writeback.
REQ-006 RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
REQ-007 LoadE  in  1  instruction in Execute is a load (ResultSrcE == 2'b01).
REQ-008 PCSrcE  in  1  taken branch, jal or jalr resolved in Execute.
REQ-009 McReqE  in  1  instruction in Execute needs the multicycle unit (mul/div).
REQ-010 McDone  in  1  multicycle unit result valid; single-cycle pulse.
REQ-011 ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
REQ-012 StallF, StallD, StallE  out  1  hold the PC, the F/D register and the D/E register.
REQ-013 FlushD, FlushE, FlushM  out  1  synchronous clear of the F/D, D/E and E/M registers.
REQ-014 McStart  out  1  one-cycle start pulse to the multicycle unit.
REQ-015 McBusy  out  1  high while the FSM state is not IDLE.
REQ-016 StallCnt, FlushCnt  out  32  performance counters; ports exist only when HAZ_PERF_CNT_EN is defined.

Function
REQ-017 Forwarding is combinational, evaluated independently per operand, with priority M > W > register file:
- Select 10 when RegWriteM and RdM != 0 and RdM == Rs1E (or Rs2E).
- Otherwise select 01 when RegWriteW and RdW != 0 and RdW == Rs1E (or Rs2E).
- Otherwise select 00.
REQ-018 Register x0 is never forwarded under any condition.
REQ-019 Load-use hazard: LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- Asserts StallF, StallD and FlushE for exactly that cycle.
- Resolves after one bubble.
REQ-020 Control hazard: PCSrcE asserts FlushD and FlushE in the same cycle.
REQ-021 When PCSrcE and a load-use hazard coincide, the flush wins: FlushD=1, FlushE=1, StallF=0, StallD=0.
REQ-022 The multicycle FSM has three states: IDLE, BUSY, DONE.
REQ-023 IDLE to BUSY when McReqE=1.
- In that IDLE cycle: McStart=1, StallF=StallD=StallE=1, FlushM=1.
REQ-024 BUSY holds StallF=StallD=StallE=1 and FlushM=1 every cycle.
- BUSY stays in BUSY while McDone=0.
- BUSY goes to DONE on McDone=1.
REQ-025 DONE releases all stalls for one cycle with FlushM=0, so Execute advances and the result enters E/M; DONE then returns to IDLE unconditionally.
REQ-026 Signals ignored by state:
- McReqE is ignored in DONE, since the same instruction is still in Execute.
- McDone is ignored in IDLE and in DONE.
REQ-027 While the FSM is stalling (the IDLE-start cycle or BUSY), load-use and control-hazard outputs are suppressed: FlushD=0, FlushE=0.
REQ-028 McReqE and PCSrcE are mutually exclusive by decode; if both are high, McReqE has priority.
REQ-029 McStart is high for at most one cycle per multicycle instruction.
REQ-030 BUSY has no timeout; the FSM waits indefinitely for McDone.

Reset
REQ-031 While rst=1:
- The FSM goes to IDLE.
- All stall, flush, McStart and McBusy outputs are 0.
- Both counters clear to 0.
REQ-032 Reset asserted in BUSY aborts the operation with no McStart re-issue, and a McDone arriving after reset is ignored.

Configuration
REQ-033 With HAZ_PERF_CNT_EN defined:
- StallCnt increments on every cycle with StallF=1.
- FlushCnt increments on every cycle with FlushD or FlushE high.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-034 Without HAZ_PERF_CNT_EN, the counters and their ports are absent and all other behaviour is identical.

Verification
REQ-035 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; then RdM=0 -> ForwardAE=01; then Rs1E=0 -> ForwardAE=00.
REQ-036 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle; with LoadE=0 the next cycle, all outputs are 0.
REQ-037 PCSrcE=1 together with a load-use hazard -> FlushD=1, FlushE=1, StallF=0.
REQ-038 McReqE=1, McDone pulsed 4 cycles later:
- McStart is a single pulse.
- StallE=1 for 5 cycles, then one DONE cycle with StallE=0, then IDLE.
REQ-039 rst=1 asserted mid-BUSY -> IDLE next edge with all outputs 0; a later McDone pulse causes no transition.
REQ-040 With HAZ_PERF_CNT_EN defined, after the REQ-038 sequence -> StallCnt=5; with StallCnt preloaded to 32'hFFFF_FFFF via force plus one more stall -> StallCnt stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a five-stage pipeline: operand forwarding, load-use stall,
// control-hazard flush and a small sequencer that parks the pipeline while an
// instruction in Execute waits on the multicycle (mul/div) unit.
//
// Ports
//   clk, rst                  pipeline clock, synchronous active-high reset
//   Rs1D, Rs2D                source registers of the instruction in Decode
//   Rs1E, Rs2E                source registers of the instruction in Execute
//   RdE, RdM, RdW             destination registers in Execute/Memory/Writeback
//   RegWriteM, RegWriteW      register-write enables in Memory/Writeback
//   LoadE                     instruction in Execute is a load
//   PCSrcE                    taken branch / jump resolved in Execute
//   McReqE, McDone            multicycle request from Execute, result-valid pulse
//   ForwardAE, ForwardBE      00 = reg file, 01 = ResultW, 10 = ALUResultM
//   StallF, StallD, StallE    hold PC, F/D and D/E registers
//   FlushD, FlushE, FlushM    clear F/D, D/E and E/M registers
//   McStart, McBusy           multicycle start pulse, sequencer not idle
//   StallCnt, FlushCnt        saturating performance counters
//
// Build option
//   HAZ_PERF_CNT_EN           when defined, adds StallCnt/FlushCnt and their
//                             counters; otherwise the ports do not exist.
//
// Multicycle sequencer states
//   state   | meaning
//   IDLE    | no multicycle op; a request here starts the unit and stalls
//   BUSY    | unit running; pipeline frozen, bubble into E/M until McDone
//   DONE    | result ready; one unstalled cycle lets Execute advance
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       McReqE,
    input  logic       McDone,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       McStart,
    output logic       McBusy
`ifdef HAZ_PERF_CNT_EN
   ,output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    mc_state_e state_q, state_d;

    logic load_use;
    logic mc_start;
    logic mc_stall;

    // Memory stage wins over Writeback because it holds the younger value.
    // x0 is hardwired to zero, so a write to it is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // A request in IDLE takes precedence over a coincident PCSrcE.
    assign mc_start = (state_q == ST_IDLE) && McReqE;
    assign mc_stall = mc_start || (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (McReqE) state_d = ST_BUSY;
            ST_BUSY: if (McDone) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // While the sequencer freezes the pipeline, Decode/Execute must not be
    // flushed: the frozen instructions are still the ones that will proceed.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        McStart = 1'b0;
        if (!rst) begin
            if (mc_stall) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                FlushM  = 1'b1;
                McStart = mc_start;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign McBusy = !rst && (state_q != ST_IDLE);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((FlushD || FlushE) && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
